// File: rtl/bit_serial_adder.sv
// Bit-serial ripple adder sequencer: drives one external full_adder cell LSB first.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_sum,
`ifdef SERIAL_ADD_OVF_EN
  input  logic             fa_carry,
  output logic             ovf
`else
  input  logic             fa_carry
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] s_next;
  logic             last_bit;

  assign s_next   = {fa_sum, s_sh[WIDTH-1:1]};
  assign last_bit = (cnt == CW'(WIDTH - 1));

  assign busy = (state == RUN);
  assign done = (state == DONE);
  // Adder inputs are gated so the cell sees zeros outside RUN.
  assign fa_a = busy & a_sh[0];
  assign fa_b = busy & b_sh[0];
  assign fa_c = busy & carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      s_sh    <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      result  <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh    <= op_a;
            b_sh    <= op_b;
            carry_q <= cin;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          s_sh    <= s_next;
          carry_q <= fa_carry;
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          cnt     <= cnt + 1'b1;
          if (last_bit) begin
            result <= s_next;
            cout   <= fa_carry;
`ifdef SERIAL_ADD_OVF_EN
            // carry_q here is the carry into the MSB.
            ovf    <= carry_q ^ fa_carry;
`endif
            state  <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder with a behavioural full_adder and arithmetic reference.
// Honours SERIAL_ADD_OVF_EN to also check the overflow output.
module tb_bit_serial_adder;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] r;
    logic         co;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout, fa_a, fa_b, fa_c, fa_sum, fa_carry;
  logic [W-1:0] result;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  assign fa_sum   = fa_a ^ fa_b ^ fa_c;
  assign fa_carry = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c), .fa_sum(fa_sum),
`ifdef SERIAL_ADD_OVF_EN
    .fa_carry(fa_carry), .ovf(ovf)
`else
    .fa_carry(fa_carry)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input int c);
    exp_t e;
    int s, sa, sb, ss;
    s  = a + b + c;
    e.r  = W'(s);
    e.co = ((s >> W) & 1) != 0;
    sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    ss = sa + sb + c;
    e.ov = (ss > (1 << (W - 1)) - 1) || (ss < -(1 << (W - 1)));
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("result", 32'(result), 32'(e.r));
          check("cout", 32'(cout), 32'(e.co));
`ifdef SERIAL_ADD_OVF_EN
          check("ovf", 32'(ovf), 32'(e.ov));
`endif
          $display("op done: result=%02h cout=%0b exp=%02h/%0b", result, cout, e.r, e.co);
        end
      end
    end
  end

  // One transaction; optionally pulses a stray start inside RUN.
  task automatic do_add(input int a, input int b, input int c, input bit inject);
    int cyc, busy_cnt, cin_bit, mask;
    bit seen;
    @(negedge clk);
    op_a = W'(a); op_b = W'(b); cin = c[0]; start = 1'b1;
    exp_q.push_back(model(a, b, c));
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0; seen = 0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      if (inject && cyc == 3) begin
        op_a = W'($urandom); op_b = W'($urandom); cin = 1'b1; start = 1'b1;
      end else if (inject && cyc == 4) begin
        start = 1'b0;
      end
      if (busy) begin
        mask = (1 << busy_cnt) - 1;
        cin_bit = ((a & mask) + (b & mask) + c) >> busy_cnt;
        check("fa_drive", {29'd0, fa_a, fa_b, fa_c},
              {29'd0, 1'((a >> busy_cnt) & 1), 1'((b >> busy_cnt) & 1), 1'(cin_bit & 1)});
        busy_cnt++;
      end
      if (done) begin
        seen = 1;
        check("latency", 32'(cyc), 32'(W + 1));
        break;
      end
      @(negedge clk);
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    check("busy_cycles", 32'(busy_cnt), 32'(W));
    $display("add a=%02h b=%02h cin=%0d busy=%0d", a, b, c, busy_cnt);
  endtask

  initial begin
    int t_prev, t_now, pulses;
    bit stable;
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_fa", {29'd0, fa_a, fa_b, fa_c}, 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_fa", {29'd0, fa_a, fa_b, fa_c}, 32'd0);

    do_add(32'h5A, 32'h25, 0, 0);
    do_add(32'hFF, 32'h01, 0, 0);
`ifdef SERIAL_ADD_OVF_EN
    do_add(32'h7F, 32'h01, 0, 0);
    do_add(32'hFF, 32'hFF, 1, 0);
`endif
    do_add(32'h33, 32'h44, 1, 1);

    // Asynchronous reset between edges during RUN.
    @(negedge clk);
    op_a = 8'hC3; op_b = 8'h3C; cin = 1'b1; start = 1'b1;
    exp_q.push_back(model(32'hC3, 32'h3C, 1));
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_result", 32'(result), 32'd0);
    check("arst_cout", 32'(cout), 32'd0);
    check("arst_fa", {29'd0, fa_a, fa_b, fa_c}, 32'd0);
    $display("async reset applied mid-run");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("arst_no_done", 32'(pulses), 32'd0);
    do_add(32'h12, 32'h34, 0, 0);

    for (int i = 0; i < 20; i++)
      do_add(int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(1)), 0);

    // Back-to-back operation with start held high.
    @(negedge clk);
    op_a = 8'h01; op_b = 8'h02; cin = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(model(1, 2, 0));
    pulses = 0; t_prev = 0; stable = 1;
    for (int cyc = 1; cyc <= 60 && pulses < 3; cyc++) begin
      @(negedge clk);
      if (pulses > 0 && result !== 8'h03) stable = 0;
      if (done) begin
        t_now = cyc;
        if (pulses > 0) check("period", 32'(t_now - t_prev), 32'(W + 2));
        t_prev = t_now;
        pulses++;
        if (pulses == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check("held_pulses", 32'(pulses), 32'd3);
    check("held_stable", 32'(stable), 32'd1);
    $display("held start: pulses=%0d", pulses);

    repeat (W + 4) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_serial_adder.md
# bit_serial_adder

Bit-serial adder sequencer that sits directly upstream of the single-bit `full_adder` and drives its `a`/`b`/`c` inputs one bit per clock, LSB first. It also consumes the adder's `sum`/`carry` outputs, feeding `carry` back and assembling the `WIDTH`-bit result. Together the two blocks form a multi-cycle ripple adder for the ALU datapath, using one full-adder cell.

## Interface
- `WIDTH`, default 8: operand and result width in bits, minimum 2.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: request a new addition; sampled only in IDLE.
- `op_a` input WIDTH: addend A; captured when `start` is accepted.
- `op_b` input WIDTH: addend B; captured when `start` is accepted.
- `cin` input 1: carry-in; captured when `start` is accepted.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse, high in the DONE state.
- `result` output WIDTH: final sum; updated only at completion and held until the next completion.
- `cout` output 1: final carry-out; same update rule as `result`.
- `fa_a` output 1: to `full_adder.a`.
- `fa_b` output 1: to `full_adder.b`.
- `fa_c` output 1: to `full_adder.c`.
- `fa_sum` input 1: from `full_adder.sum`.
- `fa_carry` input 1: from `full_adder.carry`.
- `ovf` output 1: signed overflow. Present only with `SERIAL_ADD_OVF_EN`.

## Operation
- Internal registers:
  - `a_sh`, `b_sh`, `s_sh`: WIDTH-bit shift registers.
  - `carry_q`: 1-bit running carry.
  - `cnt`: bit counter, clog2(WIDTH+1) bits.
  - `state`: IDLE, RUN or DONE.
- IDLE:
  - `busy` = 0 and `done` = 0.
  - `fa_a`, `fa_b` and `fa_c` are driven 0.
  - When `start` = 1: load `a_sh` = `op_a`, `b_sh` = `op_b`, `carry_q` = `cin`, `cnt` = 0, then go to RUN.
- RUN:
  - Combinational drive: `fa_a` = `a_sh[0]`, `fa_b` = `b_sh[0]`, `fa_c` = `carry_q`.
  - On each edge: `s_sh` <= {`fa_sum`, `s_sh[WIDTH-1:1]`}; `carry_q` <= `fa_carry`; `a_sh` and `b_sh` shift right; `cnt` increments.
  - On the edge where `cnt` = WIDTH-1 (the last bit):
    - `result` <= {`fa_sum`, `s_sh[WIDTH-1:1]`}.
    - `cout` <= `fa_carry`.
    - Go to DONE.
- DONE: `done` = 1 for exactly one cycle, then go to IDLE unconditionally.
- Start handling:
  - `start` in RUN or DONE is ignored, neither queued nor latched.
  - `start` held high through DONE is accepted in the following IDLE cycle.
- Arithmetic: `result` = (`op_a` + `op_b` + `cin`) mod 2^WIDTH, and `cout` = bit WIDTH of that sum. Wrap-around is not flagged except through `cout` (and `ovf` when enabled).
- Reset in any state: everything returns to IDLE, and all outputs and registers clear to 0. Any in-flight operation is discarded and no `done` is issued.

## Timing
- Reset values: `busy` = 0, `done` = 0, `result` = 0, `cout` = 0, `fa_a` = `fa_b` = `fa_c` = 0, `ovf` = 0.
- Sequence for a `start` sampled at edge E0:
  - RUN occupies the cycles after edges E0 to E0+WIDTH-1, i.e. WIDTH cycles with `busy` = 1.
  - `result` and `cout` become valid, and `done` = 1, in the cycle after edge E0+WIDTH.
- Latency: `done` is high WIDTH+1 cycles after `start` is sampled.
- Throughput: one addition per WIDTH+2 cycles when `start` is held high.
- The `full_adder` is combinational. The path `fa_*` -> `full_adder` -> `fa_sum`/`fa_carry` -> registers must close within one cycle.

## Configuration
- `SERIAL_ADD_OVF_EN` defined:
  - Adds the `ovf` port and register.
  - On the last RUN edge, `ovf` <= `carry_q` XOR `fa_carry` (carry into the MSB XOR carry out of the MSB).
  - `ovf` holds with `result`; it resets to 0.
- Undefined: no `ovf` port and no extra logic. All other behaviour is identical.

## Test plan
- WIDTH=8, reset released, then `op_a`=8'h5A, `op_b`=8'h25, `cin`=0 -> `busy` high for 8 cycles; `done` pulses once 9 cycles after `start`; `result`=8'h7F, `cout`=0.
- `op_a`=8'hFF, `op_b`=8'h01, `cin`=0 -> `result`=8'h00, `cout`=1. Check the `fa_c` sequence is 0, then 1 for bits 1-7.
- With `SERIAL_ADD_OVF_EN`: `op_a`=8'h7F, `op_b`=8'h01 -> `result`=8'h80, `cout`=0, `ovf`=1. Then 8'hFF + 8'hFF with `cin`=1 -> `result`=8'hFF, `cout`=1, `ovf`=0.
- `start` pulsed with new operands 3 cycles into RUN -> ignored; the original sum completes unchanged, and only one `done` pulse occurs.
- `rst_n` driven low asynchronously mid-RUN (between edges) -> `busy`, `result` and `fa_*` read 0 immediately. No `done` follows. The next `start` after release produces the correct sum.
- `start` held high continuously with 8'h01 + 8'h02 -> `done` every 10 cycles with `result`=8'h03, and `result` is stable between pulses.
